// File: rtl/stack_accum_pkg.sv
// stack_accum_pkg
//   Shared encodings for the burst-driven LIFO stack with reduction.
//   op_e    : per-cycle stack operation carried on OP.
//   mode_e  : reduction reported at the end of a burst, carried on MODE.
//   state_e : burst tracking state of stack_accum.
package stack_accum_pkg;

  typedef enum logic [1:0] {
    POP   = 2'b00,
    PUSH  = 2'b01,
    CLEAR = 2'b10,
    NOP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SUM = 2'b00,
    MAX = 2'b01,
    MIN = 2'b10,
    TOP = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BURST  = 2'b01,
    REPORT = 2'b10
  } state_e;

endpackage

// File: rtl/stack_reduce.sv
// stack_reduce
//   Combinational max / min / top selection over the live part of the stack.
//   Only entries 0..count_i-1 take part; everything above is stale.
//   With count_i == 0 all three results are 0.
// Ports:
//   count_i   : number of live entries
//   entries_i : raw storage array, entry 0 is the bottom of the stack
//   max_o     : largest live entry
//   min_o     : smallest live entry
//   top_o     : entry[count_i-1]
module stack_reduce #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic [CNT_W-1:0]  count_i,
  input  logic [DATA_W-1:0] entries_i [DEPTH],
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] top_o
);

  always_comb begin
    max_o = '0;
    min_o = '1;
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_i) begin
        if (entries_i[i] > max_o) max_o = entries_i[i];
        if (entries_i[i] < min_o) min_o = entries_i[i];
      end
      if (CNT_W'(i + 1) == count_i) top_o = entries_i[i];
    end
    // The all-ones seed for min must not leak out of an empty stack.
    if (count_i == '0) min_o = '0;
  end

endmodule

// File: rtl/stack_accum.sv
// stack_accum
//   LIFO stack driven by bursts of operations (consecutive IN_VALID cycles).
//   After each burst ends, one reduction (sum/max/min/top) of the current
//   contents is reported together with sticky overflow/underflow flags.
//   Stack contents persist across bursts.
// Ports:
//   CLK, RESET : clock and synchronous active-high reset
//   IN_VALID   : operation valid; consecutive high cycles form one burst
//   OP         : 00 pop, 01 push, 10 clear, 11 nop
//   IN         : push data
//   MODE       : reduction select, latched on the first cycle of a burst
//   OUT        : reduction result, zero-extended (qualified by OUT_VALID)
//   OUT_VALID  : one-cycle result strobe
//   OVF / UNF  : push on full / pop on empty seen in the burst
//   EMPTY      : stack empty at report time
//   COUNT      : live occupancy
module stack_accum
  import stack_accum_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int SUM_W  = 6,
  parameter int CNT_W  = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  input  logic [1:0]        OP,
  input  logic [DATA_W-1:0] IN,
  input  logic [1:0]        MODE,
  output logic [SUM_W-1:0]  OUT,
  output logic              OUT_VALID,
  output logic              OVF,
  output logic              UNF,
  output logic              EMPTY,
  output logic [CNT_W-1:0]  COUNT
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  state_e            state_q;
  mode_e             mode_q;
  logic              ovf_sticky_q, unf_sticky_q;
  logic [SUM_W-1:0]  out_q;
  logic              out_valid_q, ovf_q, unf_q, empty_q;

  logic              push_ok, ovf_hit, unf_hit;
  logic [DATA_W-1:0] max_val, min_val, top_val;
  logic [SUM_W-1:0]  red_d;
  op_e               op;

  assign op = op_e'(OP);

  stack_reduce #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_reduce (
    .count_i   (count_q),
    .entries_i (mem_q),
    .max_o     (max_val),
    .min_o     (min_val),
    .top_o     (top_val)
  );

  // Next occupancy / running sum for the operation on the inputs.
  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    push_ok = 1'b0;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    case (op)
      PUSH: begin
        if (count_q < CNT_W'(DEPTH)) begin
          push_ok = 1'b1;
          count_d = count_q + 1'b1;
          sum_d   = sum_q + SUM_W'(IN);
        end else begin
          ovf_hit = 1'b1;
        end
      end
      POP: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
          // top_val is entry[count-1], exactly the value leaving the stack.
          sum_d   = sum_q - SUM_W'(top_val);
        end else begin
          unf_hit = 1'b1;
        end
      end
      CLEAR: begin
        count_d = '0;
        sum_d   = '0;
      end
      default: ;
    endcase
  end

  // Reduction of the contents as they stand when the burst has ended.
  always_comb begin
    red_d = '0;
    if (count_q != '0) begin
      case (mode_q)
        SUM:     red_d = sum_q;
        MAX:     red_d = SUM_W'(max_val);
        MIN:     red_d = SUM_W'(min_val);
        default: red_d = SUM_W'(top_val);
      endcase
    end
  end

  // Storage has no reset: entries above count are never observed.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge CLK) begin
        if (!RESET && IN_VALID && push_ok && (count_q == CNT_W'(gi))) begin
          mem_q[gi] <= IN;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      mode_q       <= SUM;
      count_q      <= '0;
      sum_q        <= '0;
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      empty_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (IN_VALID) begin
        count_q <= count_d;
        sum_q   <= sum_d;
        state_q <= BURST;
        if (state_q != BURST) begin
          // First cycle of a burst; a report in flight keeps its own outputs.
          mode_q       <= mode_e'(MODE);
          ovf_sticky_q <= ovf_hit;
          unf_sticky_q <= unf_hit;
        end else begin
          ovf_sticky_q <= ovf_sticky_q | ovf_hit;
          unf_sticky_q <= unf_sticky_q | unf_hit;
        end
      end else begin
        case (state_q)
          BURST: begin
            out_q       <= red_d;
            ovf_q       <= ovf_sticky_q;
            unf_q       <= unf_sticky_q;
            empty_q     <= (count_q == '0);
            out_valid_q <= 1'b1;
            state_q     <= REPORT;
          end
          REPORT:  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign OVF       = ovf_q;
  assign UNF       = unf_q;
  assign EMPTY     = empty_q;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_stack_accum.sv
// tb_stack_accum
//   Directed bench for stack_accum (DATA_W=4, DEPTH=4, SUM_W=6).
//   Inputs are driven 1 time unit after each rising edge, outputs sampled there.
module tb_stack_accum;
  import stack_accum_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       IN_VALID = 1'b0;
  logic [1:0] OP = 2'b11;
  logic [3:0] IN = '0;
  logic [1:0] MODE = 2'b00;
  logic [5:0] OUT;
  logic       OUT_VALID, OVF, UNF, EMPTY;
  logic [2:0] COUNT;

  int n_checks = 0;
  int n_pass   = 0;

  stack_accum #(.DATA_W(4), .DEPTH(4), .SUM_W(6), .CNT_W(3)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .OP        (OP),
    .IN        (IN),
    .MODE      (MODE),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OVF       (OVF),
    .UNF       (UNF),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET    = 1'b1;
    IN_VALID = 1'b0;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [3:0] data, input logic [1:0] mode);
    IN_VALID = 1'b1;
    OP       = op;
    IN       = data;
    MODE     = mode;
    step();
  endtask

  // Ends the burst, checks the single report cycle, then that the strobe drops.
  task automatic expect_report(input string tag, input int exp_out, input bit exp_ovf,
                               input bit exp_unf, input bit exp_empty, input int exp_count);
    IN_VALID = 1'b0;
    OP       = 2'b11;
    step();
    $display("report %s: OUT_VALID=%0b OUT=%0d OVF=%0b UNF=%0b EMPTY=%0b COUNT=%0d",
             tag, OUT_VALID, OUT, OVF, UNF, EMPTY, COUNT);
    check({tag, ".valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, ".out"},   32'(OUT),       32'(exp_out));
    check({tag, ".ovf"},   32'(OVF),       32'(exp_ovf));
    check({tag, ".unf"},   32'(UNF),       32'(exp_unf));
    check({tag, ".empty"}, 32'(EMPTY),     32'(exp_empty));
    check({tag, ".count"}, 32'(COUNT),     32'(exp_count));
    step();
    check({tag, ".pulse_end"}, 32'(OUT_VALID), 32'd0);
  endtask

  initial begin
    int pulses;

    // Reset state
    do_reset();
    $display("reset: OUT=%0d OUT_VALID=%0b COUNT=%0d", OUT, OUT_VALID, COUNT);
    check("rst.out",   32'(OUT),       32'd0);
    check("rst.valid", 32'(OUT_VALID), 32'd0);
    check("rst.ovf",   32'(OVF),       32'd0);
    check("rst.unf",   32'(UNF),       32'd0);
    check("rst.empty", 32'(EMPTY),     32'd0);
    check("rst.count", 32'(COUNT),     32'd0);

    // 1: push 3,5,7,9; MODE only counts on the first cycle, so sum = 24
    do_op(PUSH, 4'd3, SUM);
    do_op(PUSH, 4'd5, MAX);
    do_op(PUSH, 4'd7, MAX);
    do_op(PUSH, 4'd9, MAX);
    expect_report("t1", 24, 1'b0, 1'b0, 1'b0, 4);

    // 2: five pushes of 15 -> 60, overflow on the fifth
    do_reset();
    for (int i = 0; i < 5; i++) do_op(PUSH, 4'd15, SUM);
    expect_report("t2", 60, 1'b1, 1'b0, 1'b0, 4);

    // 3: pop on empty
    do_reset();
    do_op(POP, 4'd0, SUM);
    expect_report("t3", 0, 1'b0, 1'b1, 1'b1, 0);

    // 4: persistence across bursts
    do_reset();
    do_op(PUSH, 4'd2, MAX);
    do_op(PUSH, 4'd9, MAX);
    do_op(PUSH, 4'd4, MAX);
    expect_report("t4a", 9, 1'b0, 1'b0, 1'b0, 3);
    do_op(POP, 4'd0, MIN);
    expect_report("t4b", 2, 1'b0, 1'b0, 1'b0, 2);
    do_op(PUSH, 4'd6, TOP);
    expect_report("t4c", 6, 1'b0, 1'b0, 1'b0, 3);

    // 5: back-to-back, new burst starts in the REPORT cycle
    do_reset();
    do_op(PUSH, 4'd3, SUM);
    do_op(PUSH, 4'd5, SUM);
    IN_VALID = 1'b0;
    step();
    $display("report t5a: OUT_VALID=%0b OUT=%0d COUNT=%0d", OUT_VALID, OUT, COUNT);
    check("t5a.valid", 32'(OUT_VALID), 32'd1);
    check("t5a.out",   32'(OUT),       32'd8);
    do_op(CLEAR, 4'd0, SUM);
    check("t5a.pulse_end", 32'(OUT_VALID), 32'd0);
    do_op(PUSH, 4'd1, SUM);
    expect_report("t5b", 1, 1'b0, 1'b0, 1'b0, 1);

    // 6: reset mid-burst discards the burst
    do_reset();
    do_op(PUSH, 4'd7, SUM);
    do_op(PUSH, 4'd7, SUM);
    RESET = 1'b1;
    step();
    RESET    = 1'b0;
    IN_VALID = 1'b0;
    pulses   = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (OUT_VALID) pulses++;
    end
    $display("reset-mid-burst: pulses=%0d COUNT=%0d OUT=%0d", pulses, COUNT, OUT);
    check("t6.pulses", 32'(pulses), 32'd0);
    check("t6.count",  32'(COUNT),  32'd0);
    check("t6.out",    32'(OUT),    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_accum.md
Name: stack_accum

Overview:
- Parametrised LIFO stack, burst-driven, with a reduction result after each burst.
- An input burst is a run of consecutive IN_VALID cycles. Each cycle carries a push, pop, clear or nop operation.
- When the burst ends, the block reports one reduction of the current stack contents (sum, max, min or top) plus per-burst error flags.
- Stack contents persist across bursts. The block sits between the command sequencer and the result collector in the lab datapath.

Parameters:
- DATA_W, 4: width of each stack entry.
- DEPTH, 4: number of entries, must be >= 2.
- SUM_W, 6: result width; must satisfy SUM_W >= DATA_W + clog2(DEPTH).
- CNT_W, 3: occupancy counter width, clog2(DEPTH+1).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  operation valid; consecutive high cycles form one burst.
- OP  in  2  operation code: 00 pop, 01 push, 10 clear, 11 nop.
- IN  in  DATA_W  push data.
- MODE  in  2  reduction select: 00 sum, 01 max, 10 min, 11 top. Latched on the first cycle of a burst.
- OUT  out  SUM_W  reduction result, zero-extended; valid only while OUT_VALID is high.
- OUT_VALID  out  1  one-cycle result strobe.
- OVF  out  1  at least one push hit a full stack during the burst; qualified by OUT_VALID.
- UNF  out  1  at least one pop hit an empty stack during the burst; qualified by OUT_VALID.
- EMPTY  out  1  stack empty at report time; qualified by OUT_VALID.
- COUNT  out  CNT_W  current occupancy, live every cycle.

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-high on RESET; clock is CLK.
  - On RESET: count=0, running sum=0, state=IDLE. OUT=0, OUT_VALID=0, OVF=0, UNF=0, EMPTY=0, COUNT=0.
  - RESET has priority over everything. Reset mid-burst discards the burst; no OUT_VALID is produced for it.
- State machine (IDLE, BURST, REPORT):
  - IDLE or REPORT with IN_VALID=1: apply OP, latch MODE, clear the sticky flags, go to BURST.
  - BURST with IN_VALID=1: apply OP, stay in BURST.
  - BURST with IN_VALID=0: register OUT, OVF, UNF and EMPTY; set OUT_VALID=1; go to REPORT.
  - REPORT with IN_VALID=0: OUT_VALID=0, go to IDLE.
- Latency: OUT_VALID rises in the cycle after the first low IN_VALID sample following a burst, and lasts exactly one cycle.
- Back-to-back bursts: IN_VALID high during the REPORT cycle is accepted. It starts a new burst and the current report is still delivered unchanged.
- Operations, applied at the rising edge while IN_VALID=1:
  - push: if count<DEPTH, write entry[count]=IN, count+1, sum+=IN. Otherwise ignore and set sticky OVF.
  - pop: if count>0, count-1, sum-=entry[count-1]. Otherwise ignore and set sticky UNF.
  - clear: count=0, sum=0. Entries are left stale.
  - nop: no change.
- Arithmetic and reduction:
  - Running sum is kept SUM_W bits wide and cannot overflow given the SUM_W constraint.
  - max and min scan entries 0..count-1 combinationally.
  - top = entry[count-1].
  - When count=0, every reduction outputs 0 and EMPTY=1.
- COUNT reflects the post-operation occupancy one cycle after each accepted op.

Decomposition:
- Shared package stack_accum_pkg holds:
  - op_e (POP, PUSH, CLEAR, NOP);
  - mode_e (SUM, MAX, MIN, TOP);
  - state_e (IDLE, BURST, REPORT).
- One sub-module, stack_reduce: combinational max/min/top selection over a DEPTH-entry array with a valid count, parametrised by DATA_W, DEPTH and CNT_W.
- The FSM, storage, running sum and flags stay in stack_accum.

Test Plan (DATA_W=4, DEPTH=4, SUM_W=6):
1. After reset, push 3,5,7,9 with MODE=sum, then IN_VALID low -> one OUT_VALID pulse with OUT=24, COUNT=4, OVF=0, UNF=0, EMPTY=0.
2. After reset, five pushes of 15 with MODE=sum -> OUT=60, OVF=1, COUNT=4.
3. After reset, a single pop burst -> OUT_VALID=1, OUT=0, UNF=1, EMPTY=1, COUNT=0.
4. Persistence across bursts:
   - push 2,9,4 with MODE=max -> OUT=9;
   - next burst: one pop with MODE=min -> OUT=2;
   - next burst: push 6 with MODE=top -> OUT=6, COUNT=3.
5. Back-to-back: stack {3,5}; reassert IN_VALID in the REPORT cycle with clear, push 1 (MODE=sum) -> first report OUT=8, second report OUT=1, COUNT=1.
6. Reset mid-burst: push 7,7, assert RESET while IN_VALID is high, then IN_VALID low -> no OUT_VALID pulse, COUNT=0, OUT=0.
